// File: rtl/arb_mux_rr.sv
// arb_mux_rr: N-channel valid/ready selector with round-robin or fixed-priority
// arbitration. The winner's data and channel index go into a one-entry output
// register that can be drained and refilled in the same cycle.
module arb_mux_rr #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned NCH       = 2,
    parameter int unsigned FIXED_PRI = 0,
    localparam int unsigned SELW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] in_data_i,
    input  logic [NCH-1:0]       in_valid_i,
    output logic [NCH-1:0]       in_ready_o,
    output logic [WIDTH-1:0]     out_data_o,
    output logic [SELW-1:0]      out_sel_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_sel_q,  out_sel_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  last_q, last_d;

    logic            gnt_valid;
    logic [SELW-1:0] gnt_idx;
    logic            can_accept;
    logic            xfer;

    // Pick the winning channel from the current requests.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        if (FIXED_PRI != 0) begin
            // Descending scan so the lowest requesting index is written last.
            for (int i = int'(NCH) - 1; i >= 0; i--) begin
                if (in_valid_i[i]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = SELW'(i);
                end
            end
        end else begin
            // Descending distance so the channel closest after last_q wins.
            for (int k = int'(NCH); k >= 1; k--) begin
                int idx;
                idx = (int'(last_q) + k) % int'(NCH);
                if (in_valid_i[idx]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = SELW'(idx);
                end
            end
        end
    end

    // Handshake: only the granted channel sees ready, and only when the
    // output slot is free or being drained this cycle.
    always_comb begin
        can_accept = !out_valid_q || out_ready_i;
        xfer       = gnt_valid && can_accept && !rst;
        in_ready_o = '0;
        if (xfer) begin
            in_ready_o[gnt_idx] = 1'b1;
        end
    end

    // Next state of the output stage and round-robin pointer.
    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        last_d      = last_q;
        if (xfer) begin
            out_data_d  = in_data_i[int'(gnt_idx)*WIDTH +: WIDTH];
            out_sel_d   = gnt_idx;
            out_valid_d = 1'b1;
            if (FIXED_PRI == 0) begin
                last_d = gnt_idx;
            end
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; pointer resets to the top channel so channel 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            last_q      <= SELW'(NCH - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_sel_o   = out_sel_q;
    assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_arb_mux_rr.sv
// Bench for arb_mux_rr: three instances (RR 4x8, fixed-priority 2x4, RR 3x5)
// exercised with a vector table, directed sequences and a random soak against
// a queue-based reference model.
module tb_arb_mux_rr;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // NCH=4, WIDTH=8, round-robin
    logic [31:0] d4 = '0;
    logic [3:0]  iv4 = '0, ir4;
    logic [7:0]  od4;
    logic [1:0]  os4;
    logic        ov4, or4 = 1'b0;

    // NCH=2, WIDTH=4, fixed priority
    logic [7:0]  d2 = '0;
    logic [1:0]  iv2 = '0, ir2;
    logic [3:0]  od2;
    logic [0:0]  os2;
    logic        ov2, or2 = 1'b0;

    // NCH=3, WIDTH=5, round-robin
    logic [14:0] d3 = '0;
    logic [2:0]  iv3 = '0, ir3;
    logic [4:0]  od3;
    logic [1:0]  os3;
    logic        ov3, or3 = 1'b0;

    arb_mux_rr #(.WIDTH(8), .NCH(4), .FIXED_PRI(0)) u_rr4 (
        .clk(clk), .rst(rst), .in_data_i(d4), .in_valid_i(iv4), .in_ready_o(ir4),
        .out_data_o(od4), .out_sel_o(os4), .out_valid_o(ov4), .out_ready_i(or4)
    );

    arb_mux_rr #(.WIDTH(4), .NCH(2), .FIXED_PRI(1)) u_fp2 (
        .clk(clk), .rst(rst), .in_data_i(d2), .in_valid_i(iv2), .in_ready_o(ir2),
        .out_data_o(od2), .out_sel_o(os2), .out_valid_o(ov2), .out_ready_i(or2)
    );

    arb_mux_rr #(.WIDTH(5), .NCH(3), .FIXED_PRI(0)) u_rr3 (
        .clk(clk), .rst(rst), .in_data_i(d3), .in_valid_i(iv3), .in_ready_o(ir3),
        .out_data_o(od3), .out_sel_o(os3), .out_valid_o(ov3), .out_ready_i(or3)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] v;
        logic [7:0] d;
        logic       ordy;
        logic [1:0] irdy;  // expected before the edge
        logic       ov;    // expected after the edge
        logic [3:0] od;
        logic       os;
    } vec_t;

    vec_t tbl[10];

    // Soak model state
    logic [6:0] pend[$];   // {sel, data} held in the output slot
    int m_last;
    int sent, delivered;
    int wait_cnt[3];
    int max_wait;

    initial begin
        // Fixed-priority vectors: ch0 = A, ch1 = 5
        tbl[0] = '{2'b11, 8'h5A, 1'b1, 2'b01, 1'b1, 4'hA, 1'b0};
        tbl[1] = '{2'b11, 8'h5A, 1'b1, 2'b01, 1'b1, 4'hA, 1'b0};
        tbl[2] = '{2'b11, 8'h5A, 1'b1, 2'b01, 1'b1, 4'hA, 1'b0};
        tbl[3] = '{2'b10, 8'h5A, 1'b1, 2'b10, 1'b1, 4'h5, 1'b1};
        tbl[4] = '{2'b00, 8'h5A, 1'b1, 2'b00, 1'b0, 4'h5, 1'b1};
        tbl[5] = '{2'b01, 8'h5A, 1'b0, 2'b01, 1'b1, 4'hA, 1'b0};
        tbl[6] = '{2'b11, 8'h5A, 1'b0, 2'b00, 1'b1, 4'hA, 1'b0};
        tbl[7] = '{2'b10, 8'h5A, 1'b0, 2'b00, 1'b1, 4'hA, 1'b0};
        tbl[8] = '{2'b10, 8'h5A, 1'b1, 2'b10, 1'b1, 4'h5, 1'b1};
        tbl[9] = '{2'b00, 8'h5A, 1'b0, 2'b00, 1'b1, 4'h5, 1'b1};

        // Reset state, with requests present to show in_ready stays low
        iv4 = 4'hF;
        d4  = 32'h33221100;
        repeat (2) @(negedge clk);
        #1;
        check("reset out_valid", ov4, 0);
        check("reset out_data", od4, 0);
        check("reset out_sel", os4, 0);
        check("reset in_ready", ir4, 0);
        @(negedge clk);
        rst = 1'b0;
        iv4 = 4'h0;

        // Fixed priority table
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            iv2 = tbl[i].v;
            d2  = tbl[i].d;
            or2 = tbl[i].ordy;
            #1;
            check($sformatf("fp2[%0d] in_ready", i), ir2, tbl[i].irdy);
            @(posedge clk);
            #1;
            check($sformatf("fp2[%0d] out_valid", i), ov2, tbl[i].ov);
            check($sformatf("fp2[%0d] out_data", i), od2, tbl[i].od);
            check($sformatf("fp2[%0d] out_sel", i), os2, tbl[i].os);
        end

        // Round-robin fairness, all four channels requesting
        @(negedge clk);
        iv4 = 4'hF;
        or4 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("rr4 fair[%0d] in_ready", k), ir4, 32'(1) << (k % 4));
            @(posedge clk);
            #1;
            check($sformatf("rr4 fair[%0d] out_sel", k), os4, k % 4);
            check($sformatf("rr4 fair[%0d] out_data", k), od4, (k % 4) * 8'h11);
            @(negedge clk);
        end

        // Backpressure: output holds ch0/00, pointer at 0
        or4 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp[%0d] in_ready", k), ir4, 0);
            @(posedge clk);
            #1;
            check($sformatf("bp[%0d] out_valid", k), ov4, 1);
            check($sformatf("bp[%0d] out_sel", k), os4, 0);
            check($sformatf("bp[%0d] out_data", k), od4, 8'h00);
            @(negedge clk);
        end
        or4 = 1'b1;
        #1;
        check("bp release in_ready", ir4, 4'b0010);
        @(posedge clk);
        #1;
        check("bp release out_sel", os4, 1);
        check("bp release out_data", od4, 8'h11);
        @(negedge clk);
        iv4 = 4'h0;
        @(posedge clk);
        #1;
        check("drain out_valid", ov4, 0);
        check("drain out_data kept", od4, 8'h11);
        check("drain out_sel kept", os4, 1);

        // Mid-stream asynchronous reset
        @(negedge clk);
        iv4 = 4'hF;
        @(posedge clk);
        #1;
        check("pre-reset out_valid", ov4, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async reset out_valid", ov4, 0);
        check("async reset out_data", od4, 0);
        check("async reset out_sel", os4, 0);
        check("async reset in_ready", ir4, 0);
        @(negedge clk);
        rst = 1'b0;
        iv4 = 4'h0;
        @(posedge clk);
        #1;
        check("idle in_ready", ir4, 0);
        check("idle out_valid", ov4, 0);
        @(negedge clk);
        iv4 = 4'hF;
        #1;
        check("post-reset ch0 first", ir4, 4'b0001);

        // Skip/wrap on NCH=3 (pointer at 2 after reset)
        @(negedge clk);
        iv4 = 4'h0;
        d3  = {5'h12, 5'h11, 5'h10};
        or3 = 1'b1;
        iv3 = 3'b010;
        #1;
        check("wrap ch1 in_ready", ir3, 3'b010);
        @(posedge clk);
        #1;
        check("wrap ch1 out_sel", os3, 1);
        check("wrap ch1 out_data", od3, 5'h11);
        @(negedge clk);
        iv3 = 3'b101;
        #1;
        check("wrap ch2 in_ready", ir3, 3'b100);
        @(posedge clk);
        #1;
        check("wrap ch2 out_sel", os3, 2);
        check("wrap ch2 out_data", od3, 5'h12);
        @(negedge clk);
        #1;
        check("wrap ch0 in_ready", ir3, 3'b001);
        @(posedge clk);
        #1;
        check("wrap ch0 out_sel", os3, 0);
        check("wrap ch0 out_data", od3, 5'h10);

        // Random soak from a fresh reset
        @(negedge clk);
        iv3 = 3'b000;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_last    = 2;
        sent      = 0;
        delivered = 0;
        max_wait  = 0;
        for (int i = 0; i < 3; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            int  g;
            bit  can;
            logic [2:0] exp_ir;
            @(negedge clk);
            iv3 = 3'($urandom);
            d3  = 15'($urandom);
            or3 = ($urandom_range(0, 3) != 0);
            #1;
            // Requests are served in order of distance after the last winner.
            g = -1;
            for (int k = 1; k <= 3 && g < 0; k++) begin
                if (iv3[(m_last + k) % 3]) g = (m_last + k) % 3;
            end
            can = (pend.size() == 0) || or3;
            exp_ir = (g >= 0 && can) ? 3'(1 << g) : 3'b000;
            check("soak in_ready", ir3, exp_ir);
            @(posedge clk);
            if (pend.size() > 0 && or3) begin
                void'(pend.pop_front());
                delivered++;
            end
            for (int i = 0; i < 3; i++) begin
                if (!iv3[i] || (g == i && can)) wait_cnt[i] = 0;
                else if (g >= 0 && can) wait_cnt[i]++;
                if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            end
            if (g >= 0 && can) begin
                pend.push_back({2'(g), d3[g*5 +: 5]});
                m_last = g;
                sent++;
            end
            #1;
            check("soak out_valid", ov3, pend.size() != 0);
            if (pend.size() != 0) begin
                check("soak out word", {os3, od3}, pend[0]);
            end
        end
        check("soak no loss", sent, delivered + pend.size());
        check("soak fairness", max_wait <= 2, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
